posit_stream_packer: RTL and testbench

- Sits directly downstream of the float-to-posit converter and consumes its N-bit posit stream.
- Packs consecutive posits into WORD_W-bit bus words, least-significant lane first, for the PPU result/memory interface.
- valid/ready handshake on both sides. A last-marker on the input flushes partially filled words.
- Counts NaR posits seen, for debug and status.

---
 rtl/posit_stream_packer.sv | 125 ++++++++++++
 tb/tb_posit_stream_packer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_stream_packer.sv
// posit_stream_packer: packs an N-bit posit stream into WORD_W-bit words,
// lane 0 in the least-significant bits, with a per-lane keep mask, a packet
// flush on in_last, and a saturating count of NaR posits accepted.
//
// Handshake: a transfer happens on a side exactly when valid && ready at a
// rising edge. The output side holds out_valid/out_word/out_keep/out_last
// stable until it transfers. in_ready is combinational: the packer takes a
// posit whenever the output register is empty or being drained this cycle.
module posit_stream_packer #(
  parameter int N      = 16,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16,
  localparam int LANES = WORD_W / N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      posit_in,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [LANES-1:0]  out_keep,
  output logic              out_last,
  output logic [CNT_W-1:0]  nar_count
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  if (((WORD_W % N) != 0) || (LANES < 2)) begin : g_param_check
    $fatal(1, "posit_stream_packer: WORD_W must be a multiple of N with at least 2 lanes");
  end

  logic [WORD_W-1:0] acc_q, acc_d, acc_new;
  logic [LANES-1:0]  keep_q, keep_d, keep_new;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_word_q, out_word_d;
  logic [LANES-1:0]  out_keep_q, out_keep_d;
  logic              out_last_q, out_last_d;
  logic [CNT_W-1:0]  nar_q, nar_d;

  logic in_fire, out_fire, complete;

  assign in_ready  = !rst && (!out_valid_q || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign complete  = in_fire && ((lane_q == LAST_LANE) || in_last);

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign nar_count = nar_q;

  // Accumulator view including the posit accepted this cycle.
  always_comb begin
    acc_new  = acc_q;
    keep_new = keep_q;
    if (in_fire) begin
      acc_new[int'(lane_q) * N +: N] = posit_in;
      keep_new[lane_q]               = 1'b1;
    end
  end

  // Next state: lane advance, word completion into the output register, drain.
  always_comb begin
    acc_d       = acc_new;
    keep_d      = keep_new;
    lane_d      = lane_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    nar_d       = nar_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (complete) begin
      // A completing word replaces a word draining in the same cycle.
      out_valid_d = 1'b1;
      out_word_d  = acc_new;
      out_keep_d  = keep_new;
      out_last_d  = in_last;
      acc_d       = '0;
      keep_d      = '0;
      lane_d      = '0;
    end else if (in_fire) begin
      lane_d = lane_q + 1'b1;
    end

    if (in_fire && (posit_in == NAR) && (nar_q != {CNT_W{1'b1}})) begin
      nar_d = nar_q + CNT_W'(1);
    end
  end

  // State registers; reset drops any partial and pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      keep_q      <= '0;
      lane_q      <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      nar_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      keep_q      <= keep_d;
      lane_q      <= lane_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      nar_q       <= nar_d;
    end
  end

endmodule

// File: tb/tb_posit_stream_packer.sv
// Bench for posit_stream_packer: an 8-bit/4-lane instance driven from a
// vector table plus a reset-mid-word sequence, and a 16-bit/2-lane instance
// with a 2-bit NaR counter for backpressure and saturation sequences.
module tb_posit_stream_packer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8 = 1'b1;
  logic rst16 = 1'b1;

  // ---------------- N=8 instance ----------------
  logic        in_valid8 = 1'b0, in_last8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0]  posit8 = '0;
  logic        in_ready8, out_valid8, out_last8;
  logic [31:0] out_word8;
  logic [3:0]  out_keep8;
  logic [15:0] nar8;

  posit_stream_packer #(.N(8), .WORD_W(32), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst8),
    .in_valid(in_valid8), .in_ready(in_ready8), .posit_in(posit8), .in_last(in_last8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_word(out_word8),
    .out_keep(out_keep8), .out_last(out_last8), .nar_count(nar8)
  );

  // ---------------- N=16 instance ----------------
  logic        in_valid16 = 1'b0, in_last16 = 1'b0, out_ready16 = 1'b1;
  logic [15:0] posit16 = '0;
  logic        in_ready16, out_valid16, out_last16;
  logic [31:0] out_word16;
  logic [1:0]  out_keep16;
  logic [1:0]  nar16;

  posit_stream_packer #(.N(16), .WORD_W(32), .CNT_W(2)) dut16 (
    .clk(clk), .rst(rst16),
    .in_valid(in_valid16), .in_ready(in_ready16), .posit_in(posit16), .in_last(in_last16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_word(out_word16),
    .out_keep(out_keep16), .out_last(out_last16), .nar_count(nar16)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];   // {last, keep[1:0], word[31:0]} for dut16

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table (dut8) ----------------
  typedef struct {
    logic        v;
    logic [7:0]  p;
    logic        l;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_word;
    logic [3:0]  e_keep;
    logic        e_last;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] p, input logic l, input logic ordy,
                     input logic e_irdy, input logic e_ov, input logic [31:0] e_word,
                     input logic [3:0] e_keep, input logic e_last);
    vec_t r;
    r.v = v; r.p = p; r.l = l; r.ordy = ordy;
    r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_word = e_word; r.e_keep = e_keep; r.e_last = e_last;
    tbl.push_back(r);
  endtask

  // ---------------- drivers ----------------
  task automatic step8(input logic v, input logic [7:0] p, input logic l, input logic ordy);
    @(negedge clk);
    in_valid8 = v; posit8 = p; in_last8 = l; out_ready8 = ordy;
    #1;
  endtask

  // Drives dut16 for one cycle and scores any word leaving this cycle.
  task automatic step16(input logic v, input logic [15:0] p, input logic l, input logic ordy);
    logic [34:0] e;
    @(negedge clk);
    in_valid16 = v; posit16 = p; in_last16 = l; out_ready16 = ordy;
    #1;
    if (out_valid16 && out_ready16) begin
      if (exp_q.size() == 0) begin
        chk("sb16_unexpected_word", out_word16, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        chk("sb16_word", out_word16, e[31:0]);
        chk("sb16_keep", {30'd0, out_keep16}, {30'd0, e[33:32]});
        chk("sb16_last", {31'd0, out_last16}, {31'd0, e[34]});
      end
    end
  endtask

  initial begin
    // ---- reset both instances ----
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_in_ready8", {31'd0, in_ready8}, 32'd0);
    chk("rst_in_ready16", {31'd0, in_ready16}, 32'd0);
    @(negedge clk);
    rst8 = 1'b0; rst16 = 1'b0;
    #1;
    chk("rst_out_valid8", {31'd0, out_valid8}, 32'd0);
    chk("rst_out_word8", out_word8, 32'd0);
    chk("rst_out_keep8", {28'd0, out_keep8}, 32'd0);
    chk("rst_out_last8", {31'd0, out_last8}, 32'd0);
    chk("rst_nar8", {16'd0, nar8}, 32'd0);
    chk("rst_out_valid16", {31'd0, out_valid16}, 32'd0);
    chk("rst_nar16", {30'd0, nar16}, 32'd0);
    chk("post_rst_in_ready8", {31'd0, in_ready8}, 32'd1);

    // ---- table: full word, flush, back-to-back ----
    //   v  p      l  rdy  irdy ov word           keep   last
    add(1, 8'h11, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'h22, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'h33, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'h44, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(0, 8'h00, 0, 1,   1,  1, 32'h44332211,   4'hF,  0);
    add(0, 8'h00, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'hAA, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'hBB, 1, 1,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'h01, 1, 1,   1,  1, 32'h0000BBAA,   4'h3,  1);
    add(0, 8'h00, 0, 1,   1,  1, 32'h00000001,   4'h1,  1);
    add(0, 8'h00, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'h01, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'h02, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'h03, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'h04, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'h05, 0, 1,   1,  1, 32'h04030201,   4'hF,  0);
    add(1, 8'h06, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'h07, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'h08, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    add(0, 8'h00, 0, 1,   1,  1, 32'h08070605,   4'hF,  0);
    add(0, 8'h00, 0, 1,   1,  0, 32'h0,          4'h0,  0);
    // backpressure on dut8: zero posit completes a one-lane packet, then hold
    add(1, 8'h00, 1, 0,   1,  0, 32'h0,          4'h0,  0);
    add(1, 8'h77, 0, 0,   0,  1, 32'h00000000,   4'h1,  1);
    add(1, 8'h77, 1, 1,   1,  1, 32'h00000000,   4'h1,  1);
    add(0, 8'h00, 0, 1,   1,  1, 32'h00000077,   4'h1,  1);
    add(0, 8'h00, 0, 1,   1,  0, 32'h0,          4'h0,  0);

    foreach (tbl[i]) begin
      step8(tbl[i].v, tbl[i].p, tbl[i].l, tbl[i].ordy);
      chk($sformatf("t%0d_in_ready", i), {31'd0, in_ready8}, {31'd0, tbl[i].e_irdy});
      chk($sformatf("t%0d_out_valid", i), {31'd0, out_valid8}, {31'd0, tbl[i].e_ov});
      if (tbl[i].e_ov) begin
        chk($sformatf("t%0d_out_word", i), out_word8, tbl[i].e_word);
        chk($sformatf("t%0d_out_keep", i), {28'd0, out_keep8}, {28'd0, tbl[i].e_keep});
        chk($sformatf("t%0d_out_last", i), {31'd0, out_last8}, {31'd0, tbl[i].e_last});
      end
    end
    chk("nar8_none", {16'd0, nar8}, 32'd0);

    // ---- dut8: reset mid-word discards partial word and NaR count ----
    step8(1, 8'h10, 0, 1);
    step8(1, 8'h80, 0, 1);
    step8(1, 8'h20, 0, 1);
    chk("mid_nar8_before_rst", {16'd0, nar8}, 32'd1);
    @(negedge clk);
    rst8 = 1'b1; in_valid8 = 1'b1; posit8 = 8'h99; in_last8 = 1'b1;
    #1;
    chk("mid_rst_in_ready8", {31'd0, in_ready8}, 32'd0);
    @(negedge clk);
    rst8 = 1'b0; in_valid8 = 1'b0; in_last8 = 1'b0;
    #1;
    chk("mid_rst_out_valid8", {31'd0, out_valid8}, 32'd0);
    chk("mid_rst_nar8", {16'd0, nar8}, 32'd0);
    step8(0, 8'h00, 0, 1);
    chk("mid_rst_idle_valid8", {31'd0, out_valid8}, 32'd0);
    step8(1, 8'h55, 1, 1);
    chk("mid_rst_accept_55", {31'd0, in_ready8}, 32'd1);
    step8(0, 8'h00, 0, 1);
    chk("mid_rst_valid_55", {31'd0, out_valid8}, 32'd1);
    chk("mid_rst_word_55", out_word8, 32'h00000055);
    chk("mid_rst_keep_55", {28'd0, out_keep8}, 32'h1);
    chk("mid_rst_last_55", {31'd0, out_last8}, 32'd1);
    step8(0, 8'h00, 0, 1);
    chk("mid_rst_drained", {31'd0, out_valid8}, 32'd0);

    // ---- dut16: 5-cycle backpressure hold ----
    exp_q.push_back({1'b0, 2'b11, 32'h22221111});
    exp_q.push_back({1'b1, 2'b11, 32'h44443333});
    step16(1, 16'h1111, 0, 0);
    chk("bp_in_ready_c0", {31'd0, in_ready16}, 32'd1);
    step16(1, 16'h2222, 0, 0);
    chk("bp_in_ready_c1", {31'd0, in_ready16}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      step16(1, 16'h3333, 0, 0);
      chk($sformatf("bp_hold%0d_in_ready", k), {31'd0, in_ready16}, 32'd0);
      chk($sformatf("bp_hold%0d_out_valid", k), {31'd0, out_valid16}, 32'd1);
      chk($sformatf("bp_hold%0d_out_word", k), out_word16, 32'h22221111);
      chk($sformatf("bp_hold%0d_out_keep", k), {30'd0, out_keep16}, 32'h3);
    end
    step16(1, 16'h3333, 0, 1);
    chk("bp_release_in_ready", {31'd0, in_ready16}, 32'd1);
    step16(1, 16'h4444, 1, 1);
    chk("bp_after_drain_valid", {31'd0, out_valid16}, 32'd0);
    step16(0, 16'h0000, 0, 1);
    chk("bp_second_valid", {31'd0, out_valid16}, 32'd1);
    step16(0, 16'h0000, 0, 1);
    chk("bp_second_drained", {31'd0, out_valid16}, 32'd0);

    // ---- dut16: NaR words and counter saturation ----
    exp_q.push_back({1'b0, 2'b11, 32'h00008000});
    exp_q.push_back({1'b1, 2'b01, 32'h00008000});
    step16(1, 16'h8000, 0, 1);
    step16(1, 16'h0000, 0, 1);
    step16(1, 16'h8000, 1, 1);
    chk("nar_first_word_valid", {31'd0, out_valid16}, 32'd1);
    step16(0, 16'h0000, 0, 1);
    chk("nar_second_word_valid", {31'd0, out_valid16}, 32'd1);
    chk("nar_count_2", {30'd0, nar16}, 32'd2);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({1'b1, 2'b01, 32'h00008000});
      step16(1, 16'h8000, 1, 1);
    end
    step16(0, 16'h0000, 0, 1);
    chk("nar_count_sat", {30'd0, nar16}, 32'd3);
    step16(0, 16'h0000, 0, 1);
    chk("nar_idle_valid", {31'd0, out_valid16}, 32'd0);
    chk("sb16_all_words_seen", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
